// File: rtl/shift_op_sequencer_pkg.sv
// Shared definitions for the shift/rotate command sequencer.
// The file holds the operation codes, the FSM state encoding and the amount normalisation rule.
package shift_op_sequencer_pkg;

   // Operation codes, matching the barrel_shifter type input
   localparam logic [1:0] OP_SHL = 2'b00;
   localparam logic [1:0] OP_SHR = 2'b01;
   localparam logic [1:0] OP_ROL = 2'b10;
   localparam logic [1:0] OP_ROR = 2'b11;

   // Sequencer FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_CAPT = 2'b10,
      ST_RESP = 2'b11
   } state_t;

   // Effective amount for a request. A rotate by a multiple of w is the identity, so rotates reduce
   // modulo w. A logical shift by w or more clears every bit, so shifts clamp to w; stepping by w
   // then yields zero and never exceeds w-1 in any single step.
   function automatic int unsigned normalise_amt(input logic [1:0] op,
                                                 input int unsigned amt,
                                                 input int unsigned w);
      if (op == OP_ROL || op == OP_ROR) begin
         return amt % w;
      end
      return (amt < w) ? amt : w;
   endfunction

endpackage

// File: rtl/shift_op_sequencer_if.sv
// Bus bundle between the sequencer, its requester/consumer and the barrel shifter.
// The slave modport is the sequencer's view; master is the environment's view.
interface shift_op_sequencer_if #(
   parameter int W     = 8,
   parameter int AMT_W = 6
);
   // Request channel
   logic             req_valid;
   logic             req_ready;
   logic [W-1:0]     req_data;
   logic [AMT_W-1:0] req_amt;
   logic [1:0]       req_type;

   // Shifter command and registered result
   logic             sh_load;
   logic [W-1:0]     sh_data;
   logic [3:0]       sh_shift;
   logic [1:0]       sh_type;
   logic [W-1:0]     sh_result;

   // Response channel
   logic             rsp_valid;
   logic             rsp_ready;
   logic [W-1:0]     rsp_data;

   modport slave (
      input  req_valid, req_data, req_amt, req_type,
      input  sh_result,
      input  rsp_ready,
      output req_ready,
      output sh_load, sh_data, sh_shift, sh_type,
      output rsp_valid, rsp_data
   );

   modport master (
      output req_valid, req_data, req_amt, req_type,
      output sh_result,
      output rsp_ready,
      input  req_ready,
      input  sh_load, sh_data, sh_shift, sh_type,
      input  rsp_valid, rsp_data
   );

endinterface

// File: rtl/shift_op_sequencer.sv
// Command sequencer in front of a barrel shifter. A request is normalised at accept, broken into
// steps of at most STEP_MAX positions, and each step recirculates the shifter's registered output.
// The final value is captured one cycle after the last step and held on the response port.
module shift_op_sequencer
   import shift_op_sequencer_pkg::*;
#(
   parameter int W        = 8,
   parameter int AMT_W    = 6,
   parameter int STEP_MAX = 4
) (
   input logic                  clock,
   input logic                  rst_n,
   shift_op_sequencer_if.slave  bus
);

   // Remaining amount never exceeds W after normalisation
   localparam int REM_W = $clog2(W + 1);
   localparam logic [REM_W-1:0] STEP_LIM = REM_W'(STEP_MAX);

   state_t           state_q;
   state_t           state_d;

   logic [W-1:0]     data_q;
   logic [1:0]       type_q;
   logic [REM_W-1:0] rem_q;
   logic             first_q;
   logic [W-1:0]     rsp_data_q;

   logic             accept;
   logic             last_step;
   logic [REM_W-1:0] step;
   logic [REM_W-1:0] amt_eff;

   assign accept    = bus.req_valid && (state_q == ST_IDLE);
   assign last_step = (rem_q <= STEP_LIM);
   assign step      = last_step ? rem_q : STEP_LIM;
   assign amt_eff   = REM_W'(normalise_amt(bus.req_type, 32'(bus.req_amt), W));

   // State register
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; RUN always issues at least one step, even for a zero amount
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept)        state_d = ST_RUN;
         ST_RUN:  if (last_step)     state_d = ST_CAPT;
         ST_CAPT:                    state_d = ST_RESP;
         ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
         default:                    state_d = ST_IDLE;
      endcase
   end

   // Request latch, step bookkeeping and result capture
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         data_q     <= '0;
         type_q     <= OP_SHL;
         rem_q      <= '0;
         first_q    <= 1'b0;
         rsp_data_q <= '0;
      end else begin
         if (accept) begin
            data_q  <= bus.req_data;
            type_q  <= bus.req_type;
            rem_q   <= amt_eff;
            first_q <= 1'b1;
         end else if (state_q == ST_RUN) begin
            rem_q   <= rem_q - step;
            first_q <= 1'b0;
         end
         // The last step's result reaches sh_result one cycle after it issues, i.e. in CAPT
         if (state_q == ST_CAPT) begin
            rsp_data_q <= bus.sh_result;
         end
      end
   end

   // Shifter drive: stepping in RUN, self-reload (hold) everywhere else
   always_comb begin
      bus.sh_load  = 1'b1;
      bus.sh_data  = bus.sh_result;
      bus.sh_shift = 4'd0;
      bus.sh_type  = OP_SHL;
      if (state_q == ST_RUN) begin
         bus.sh_load  = 1'b0;
         bus.sh_type  = type_q;
         bus.sh_shift = 4'(step);
         bus.sh_data  = first_q ? data_q : bus.sh_result;
      end
      // The shifter itself may not be reset, so its output is masked while reset is asserted
      if (!rst_n) begin
         bus.sh_data = '0;
      end
   end

   assign bus.req_ready = (state_q == ST_IDLE);
   assign bus.rsp_valid = (state_q == ST_RESP);
   assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_shift_op_sequencer.sv
// Bench for shift_op_sequencer with a behavioural registered barrel shifter behind it.
// A negedge monitor records accepted requests into scoreboard queues and checks steps and responses.
module tb_shift_op_sequencer;
   import shift_op_sequencer_pkg::*;

   localparam int W        = 8;
   localparam int AMT_W    = 6;
   localparam int STEP_MAX = 4;

   logic clock = 1'b0;
   logic rst_n = 1'b0;
   always #5 clock = ~clock;

   shift_op_sequencer_if #(.W(W), .AMT_W(AMT_W)) bus ();

   shift_op_sequencer #(.W(W), .AMT_W(AMT_W), .STEP_MAX(STEP_MAX)) dut (
      .clock (clock),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Behavioural barrel shifter: registered, one-cycle latency, amount below W
   function automatic logic [W-1:0] shifter_fn(input logic [W-1:0] d, input logic [3:0] s,
                                               input logic [1:0] t);
      int sh;
      sh = int'(s);
      case (t)
         OP_SHL:  return d << sh;
         OP_SHR:  return d >> sh;
         OP_ROL:  return (d << sh) | (d >> (W - sh));
         default: return (d >> sh) | (d << (W - sh));
      endcase
   endfunction

   always @(posedge clock or negedge rst_n) begin
      if (!rst_n) bus.sh_result <= '0;
      else        bus.sh_result <= shifter_fn(bus.sh_data, bus.sh_shift, bus.sh_type);
   end

   // Reference result from bit positions on the raw amount
   function automatic logic [W-1:0] ref_result(input logic [W-1:0] d, input int amt,
                                               input logic [1:0] t);
      logic [W-1:0] r;
      int src;
      r = '0;
      for (int i = 0; i < W; i++) begin
         case (t)
            OP_SHL: begin src = i - amt; r[i] = (src >= 0) ? d[src] : 1'b0; end
            OP_SHR: begin src = i + amt; r[i] = (src < W) ? d[src] : 1'b0; end
            OP_ROL: begin src = ((i - amt) % W + W) % W; r[i] = d[src]; end
            default: begin src = (i + amt) % W; r[i] = d[src]; end
         endcase
      end
      return r;
   endfunction

   typedef struct { logic [W-1:0] res; int lat; int acc_cyc; } exp_t;
   typedef struct { int shift; logic [1:0] typ; } step_t;

   exp_t  exp_q[$];
   step_t step_q[$];
   exp_t  cur;
   logic  rsp_active = 1'b0;
   int    cyc = 0;
   int    n_checks = 0;
   int    n_fail = 0;
   logic  bp_en = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
   endtask

   // Monitor / scoreboard
   always @(negedge clock) begin
      if (!rst_n) begin
         exp_q.delete();
         step_q.delete();
         rsp_active = 1'b0;
      end else begin
         if (bus.rsp_valid) begin
            check("req_ready_in_resp", 32'(bus.req_ready), 32'd0);
            if (!rsp_active) begin
               if (exp_q.size() == 0) begin
                  fail_now("unexpected_rsp");
               end else begin
                  cur = exp_q.pop_front();
                  rsp_active = 1'b1;
                  check("rsp_data", 32'(bus.rsp_data), 32'(cur.res));
                  check("rsp_latency", 32'(cyc - cur.acc_cyc), 32'(cur.lat));
               end
            end else begin
               check("rsp_stable", 32'(bus.rsp_data), 32'(cur.res));
            end
            if (bus.rsp_ready) rsp_active = 1'b0;
         end
         if (!bus.sh_load) begin
            if (step_q.size() == 0) begin
               fail_now("unexpected_step");
            end else begin
               step_t s;
               s = step_q.pop_front();
               check("step_shift", 32'(bus.sh_shift), 32'(s.shift));
               check("step_type", 32'(bus.sh_type), 32'(s.typ));
            end
         end
         if (bus.req_valid && bus.req_ready) begin
            exp_t  e;
            step_t s;
            int    a, nsteps;
            a = int'(normalise_amt(bus.req_type, 32'(bus.req_amt), W));
            nsteps = (a == 0) ? 1 : (a + STEP_MAX - 1) / STEP_MAX;
            e.res = ref_result(bus.req_data, int'(bus.req_amt), bus.req_type);
            e.lat = nsteps + 2;
            e.acc_cyc = cyc;
            exp_q.push_back(e);
            for (int k = 0; k < nsteps; k++) begin
               s.shift = (a - k * STEP_MAX > STEP_MAX) ? STEP_MAX : a - k * STEP_MAX;
               s.typ = bus.req_type;
               step_q.push_back(s);
            end
         end
      end
   end

   task automatic check_reset();
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
      check("rst_sh_load", 32'(bus.sh_load), 32'd1);
      check("rst_sh_data", 32'(bus.sh_data), 32'd0);
      check("rst_sh_shift", 32'(bus.sh_shift), 32'd0);
      check("rst_sh_type", 32'(bus.sh_type), 32'd0);
   endtask

   // Entered just after a rising edge; returns just after the edge that follows acceptance
   task automatic send(input logic [W-1:0] d, input int amt, input logic [1:0] t);
      int k;
      bus.req_valid = 1'b1;
      bus.req_data  = d;
      bus.req_amt   = AMT_W'(amt);
      bus.req_type  = t;
      k = 0;
      @(negedge clock);
      while (!bus.req_ready && k < 200) begin
         @(negedge clock);
         k++;
      end
      if (!bus.req_ready) fail_now("accept_timeout");
      @(posedge clock); #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while ((exp_q.size() != 0 || bus.rsp_valid) && k < 300) begin
         @(posedge clock); #1;
         k++;
      end
      if (exp_q.size() != 0 || bus.rsp_valid) fail_now("drain_timeout");
      @(posedge clock); #1;
   endtask

   // Random response backpressure
   initial begin
      forever begin
         @(posedge clock); #1;
         if (bp_en) bus.rsp_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Stimulus
   initial begin
      int k;
      bus.req_valid = 1'b0;
      bus.req_data  = '0;
      bus.req_amt   = '0;
      bus.req_type  = OP_SHL;
      bus.rsp_ready = 1'b1;
      #2;
      check_reset();
      repeat (2) @(posedge clock);
      #1 rst_n = 1'b1;
      @(posedge clock); #1;

      send(8'h81, 3, OP_SHL);   wait_done();
      send(8'h01, 7, OP_ROL);   wait_done();
      send(8'h81, 13, OP_ROR);  wait_done();
      send(8'hFF, 20, OP_SHR);  wait_done();
      send(8'h5A, 0, OP_SHL);   wait_done();
      send(8'hC3, 8, OP_ROL);   wait_done();
      send(8'hFF, 63, OP_SHL);  wait_done();
      send(8'h96, 7, OP_SHR);   wait_done();

      // Backpressure: response held while a new request waits
      bus.rsp_ready = 1'b0;
      send(8'h3C, 2, OP_SHR);
      bus.req_valid = 1'b1;
      bus.req_data  = 8'hA5;
      bus.req_amt   = AMT_W'(9);
      bus.req_type  = OP_ROR;
      k = 0;
      @(negedge clock);
      while (!bus.rsp_valid && k < 50) begin
         @(negedge clock);
         k++;
      end
      if (!bus.rsp_valid) fail_now("bp_rsp_timeout");
      for (int i = 0; i < 4; i++) @(negedge clock);
      @(posedge clock); #1;
      bus.rsp_ready = 1'b1;
      @(negedge clock);
      @(negedge clock);
      check("accept_after_resp", 32'(bus.req_ready), 32'd1);
      @(posedge clock); #1;
      bus.req_valid = 1'b0;
      wait_done();

      // Reset during the second step of a two-step rotate
      send(8'h01, 7, OP_ROL);
      @(posedge clock); #2;
      rst_n = 1'b0;
      #1;
      check_reset();
      repeat (2) @(posedge clock);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         check("no_rsp_after_reset", 32'(bus.rsp_valid), 32'd0);
      end
      @(posedge clock); #1;
      send(8'hC3, 6, OP_ROR);   wait_done();

      // Randomised traffic with response backpressure
      bp_en = 1'b1;
      for (int i = 0; i < 80; i++) begin
         int amt;
         case ($urandom_range(0, 4))
            0:       amt = 0;
            1:       amt = 63;
            2:       amt = W * int'($urandom_range(0, 7));
            default: amt = int'($urandom_range(0, 63));
         endcase
         send(W'($urandom), amt, 2'($urandom_range(0, 3)));
      end
      bp_en = 1'b0;
      bus.rsp_ready = 1'b1;
      wait_done();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
